// File: rtl/pkt_sf_fifo_avlstrm.sv
// Store-and-forward packet FIFO (Avalon-ST style) between the packet mux and the TX MAC.
// A packet becomes readable only once its eop beat is stored, so the output never
// starves mid-packet. A packet that alone fills the whole buffer is rewound and dropped.
module pkt_sf_fifo_avlstrm #(
  parameter int DATA_BITS  = 512,
  parameter int EMPTY_BITS = 6,
  parameter int DEPTH      = 64,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_BITS-1:0]  in_data,
  input  logic                  in_sop,
  input  logic                  in_eop,
  input  logic [EMPTY_BITS-1:0] in_empty,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_BITS-1:0]  out_data,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [EMPTY_BITS-1:0] out_empty,
  output logic [AW:0]           pkt_avail,
  output logic [AW:0]           used_words,
  output logic [31:0]           tx_pkt_cnt,
  output logic [31:0]           drop_cnt
);

  localparam int          EW      = DATA_BITS + EMPTY_BITS + 2;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_W   = (AW+1)'(1);
  localparam logic [AW:0] ZERO_W  = (AW+1)'(0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DROP  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [EW-1:0] r_mem [DEPTH];
  logic [EW-1:0] r_out_beat;
  logic          r_out_valid;
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_wr_commit;
  logic [AW:0]   r_rd_ptr;
  logic [AW:0]   r_pkt_avail;
  logic [31:0]   r_tx_cnt;
  logic [31:0]   r_drop_cnt;
  logic          r_en;

  logic [AW:0]   w_used;
  logic [AW:0]   w_fetch_ptr;
  logic [AW-1:0] w_fetch_addr;
  logic          w_full;
  logic          w_in_fire;
  logic          w_out_take;
  logic          w_out_last;
  logic          w_fetch;
  logic          w_wr_en;
  logic          w_commit;
  logic          w_rewind;
  logic          w_drop_done;

  // The entry sitting in the output register still counts as occupied; rd_ptr
  // only moves when the MAC takes a beat, so rd_ptr always addresses the output beat.
  assign w_used       = r_wr_ptr - r_rd_ptr;
  assign w_full       = (w_used == DEPTH_W);
  assign in_ready     = r_en & (~w_full | (r_state == ST_DROP));
  assign w_in_fire    = in_valid & in_ready;
  assign w_out_take   = r_out_valid & out_ready;
  assign w_out_last   = w_out_take & r_out_beat[EW-2];
  assign w_fetch_ptr  = r_rd_ptr + {{AW{1'b0}}, w_out_take};
  assign w_fetch_addr = w_fetch_ptr[AW-1:0];
  // Only committed entries (below wr_commit) are ever fetched.
  assign w_fetch      = (~r_out_valid | out_ready) & (w_fetch_ptr != r_wr_commit) &
                        (r_pkt_avail != ZERO_W);

  // Write FSM: next state and per-cycle write/commit/rewind/drop strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    w_commit    = 1'b0;
    w_rewind    = 1'b0;
    w_drop_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_in_fire && in_sop) begin
          w_wr_en = 1'b1;
          if (in_eop) begin
            w_commit    = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_WRITE;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (w_full && (r_pkt_avail == ZERO_W)) begin
          // The current packet alone fills the buffer: it can never fit.
          w_rewind    = 1'b1;
          w_state_nxt = ST_DROP;
        end else if (w_in_fire) begin
          w_wr_en = 1'b1;
          if (in_eop) begin
            w_commit    = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_WRITE;
          end
        end else begin
          w_state_nxt = ST_WRITE;
        end
      end
      ST_DROP: begin
        if (w_in_fire && in_eop) begin
          w_drop_done = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DROP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Packet storage array; contents need no reset since pointers gate every read.
  always_ff @(posedge Clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {in_sop, in_eop, in_empty, in_data};
    end
  end

  // FSM state, pointers, packet count and statistics counters.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_en        <= 1'b0;
      r_state     <= ST_IDLE;
      r_wr_ptr    <= ZERO_W;
      r_wr_commit <= ZERO_W;
      r_rd_ptr    <= ZERO_W;
      r_pkt_avail <= ZERO_W;
      r_tx_cnt    <= 32'd0;
      r_drop_cnt  <= 32'd0;
    end else begin
      r_en    <= 1'b1;
      r_state <= w_state_nxt;
      if (w_rewind) begin
        r_wr_ptr <= r_wr_commit;
      end else if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + ONE_W;
      end
      if (w_commit) begin
        r_wr_commit <= r_wr_ptr + ONE_W;
      end
      if (w_out_take) begin
        r_rd_ptr <= r_rd_ptr + ONE_W;
      end
      case ({w_commit, w_out_last})
        2'b10:   r_pkt_avail <= r_pkt_avail + ONE_W;
        2'b01:   r_pkt_avail <= r_pkt_avail - ONE_W;
        default: r_pkt_avail <= r_pkt_avail;
      endcase
      if (w_out_last) begin
        r_tx_cnt <= r_tx_cnt + 32'd1;
      end
      if (w_drop_done) begin
        r_drop_cnt <= r_drop_cnt + 32'd1;
      end
    end
  end

  // Output register doubles as the RAM read register: refills whenever empty or consumed.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_out_valid <= 1'b0;
      r_out_beat  <= {EW{1'b0}};
    end else if (w_fetch) begin
      r_out_valid <= 1'b1;
      r_out_beat  <= r_mem[w_fetch_addr];
    end else if (w_out_take) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_sop    = r_out_beat[EW-1];
  assign out_eop    = r_out_beat[EW-2];
  assign out_empty  = r_out_beat[EW-3 -: EMPTY_BITS];
  assign out_data   = r_out_beat[DATA_BITS-1:0];
  assign pkt_avail  = r_pkt_avail;
  assign used_words = w_used;
  assign tx_pkt_cnt = r_tx_cnt;
  assign drop_cnt   = r_drop_cnt;

endmodule
